// File: rtl/odd_chk_pkg.sv
// Shared types and constants for the odd-count sequence checker.
package odd_chk_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int ODD_INIT = 1;
    localparam int ODD_STEP = 2;

    // Width of the observed count bus for a given counter length.
    function automatic int count_width(input int count_len);
        return count_len + 1;
    endfunction

endpackage

// File: rtl/odd_count_checker_sat_counter.sv
// Saturating event counter; a same-cycle clear wins over an increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/odd_count_checker.sv
// Monitors an odd-count stream: acquires lock, flywheels the expected value,
// and flags mismatches, even samples and loss of lock.
module odd_count_checker
    import odd_chk_pkg::*;
#(
    parameter int COUNT_LEN   = 10,
    parameter int LOCK_THRESH = 4,
    parameter int MAX_MISS    = 3,
    parameter int ERR_W       = 8,
    parameter int MATCH_W     = 16,
    localparam int W          = count_width(COUNT_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [W-1:0]       count_in,
    input  logic               clear_stats,
    output logic               locked,
    output logic               mismatch,
    output logic               even_err,
    output logic [W-1:0]       expected,
    output logic [ERR_W-1:0]   err_count,
    output logic [MATCH_W-1:0] match_count
);

    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W = $clog2(MAX_MISS + 1);
    localparam logic [RUN_W-1:0]  LOCK_RUN = RUN_W'(LOCK_THRESH);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MAX_MISS);

    state_t              state;
    logic [RUN_W-1:0]    run;
    logic [MISS_W-1:0]   miss;

    logic                odd;
    logic                hit;
    logic [W-1:0]        step_exp;
    logic [W-1:0]        step_in;
    logic [RUN_W-1:0]    run_inc;
    logic [MISS_W-1:0]   miss_inc;
    logic                err_inc;
    logic                match_inc;

    // Wrap past all-ones lands back on 1 because the step is even and the bus is odd.
    always_comb begin
        odd       = count_in[0];
        hit       = (count_in == expected);
        step_exp  = expected + W'(ODD_STEP);
        step_in   = count_in + W'(ODD_STEP);
        run_inc   = run + 1'b1;
        miss_inc  = miss + 1'b1;
        err_inc   = sample_valid && (!odd || ((state == LOCKED) && !hit));
        match_inc = sample_valid && odd && (state == LOCKED) && hit;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            mismatch <= 1'b0;
            even_err <= 1'b0;
            expected <= W'(ODD_INIT);
            run      <= '0;
            miss     <= '0;
        end else begin
            mismatch <= 1'b0;
            even_err <= 1'b0;
            if (sample_valid) begin
                if (!odd) begin
                    even_err <= 1'b1;
                    state    <= SEARCH;
                    locked   <= 1'b0;
                    run      <= '0;
                    miss     <= '0;
                end else begin
                    unique case (state)
                        SEARCH: begin
                            expected <= step_in;
                            run      <= RUN_W'(1);
                            if (LOCK_THRESH == 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                miss   <= '0;
                            end else begin
                                state  <= ACQUIRE;
                            end
                        end
                        ACQUIRE: begin
                            if (hit) begin
                                expected <= step_exp;
                                run      <= run_inc;
                                if (run_inc == LOCK_RUN) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                    miss   <= '0;
                                end
                            end else begin
                                expected <= step_in;
                                run      <= RUN_W'(1);
                            end
                        end
                        LOCKED: begin
                            expected <= step_exp;
                            if (hit) begin
                                miss <= '0;
                            end else begin
                                mismatch <= 1'b1;
                                if (miss_inc == MISS_LIM) begin
                                    state  <= SEARCH;
                                    locked <= 1'b0;
                                    run    <= '0;
                                    miss   <= '0;
                                end else begin
                                    miss <= miss_inc;
                                end
                            end
                        end
                        default: begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_stats),
        .inc   (err_inc),
        .q     (err_count)
    );

    sat_counter #(.WIDTH(MATCH_W)) u_match_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_stats),
        .inc   (match_inc),
        .q     (match_count)
    );

endmodule

// File: tb/tb_odd_count_checker.sv
// Directed self-checking bench: default instance plus a COUNT_LEN=3 instance for wrap.
module tb_odd_count_checker;

    logic        clk;
    logic        reset;

    logic        sample_valid;
    logic [10:0] count_in;
    logic        clear_stats;
    logic        locked;
    logic        mismatch;
    logic        even_err;
    logic [10:0] expected;
    logic [7:0]  err_count;
    logic [15:0] match_count;

    logic        sample_valid_4;
    logic [3:0]  count_in_4;
    logic        clear_stats_4;
    logic        locked_4;
    logic        mismatch_4;
    logic        even_err_4;
    logic [3:0]  expected_4;
    logic [7:0]  err_count_4;
    logic [15:0] match_count_4;

    int total;
    int bad;

    odd_count_checker dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .count_in     (count_in),
        .clear_stats  (clear_stats),
        .locked       (locked),
        .mismatch     (mismatch),
        .even_err     (even_err),
        .expected     (expected),
        .err_count    (err_count),
        .match_count  (match_count)
    );

    odd_count_checker #(.COUNT_LEN(3)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid_4),
        .count_in     (count_in_4),
        .clear_stats  (clear_stats_4),
        .locked       (locked_4),
        .mismatch     (mismatch_4),
        .even_err     (even_err_4),
        .expected     (expected_4),
        .err_count    (err_count_4),
        .match_count  (match_count_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [10:0] val, input logic clr);
        @(negedge clk);
        sample_valid = v;
        count_in     = val;
        clear_stats  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic [3:0] val);
        @(negedge clk);
        sample_valid_4 = v;
        count_in_4     = val;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        sample_valid = 1'b0;
        clear_stats  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lock_up();
        drive(1'b1, 11'd1, 1'b0);
        drive(1'b1, 11'd3, 1'b0);
        drive(1'b1, 11'd5, 1'b0);
        drive(1'b1, 11'd7, 1'b0);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        sample_valid   = 1'b0;
        count_in       = '0;
        clear_stats    = 1'b0;
        sample_valid_4 = 1'b0;
        count_in_4     = '0;
        clear_stats_4  = 1'b0;
        #12;
        check("rst_locked",   locked,      0);
        check("rst_expected", expected,    1);
        check("rst_err",      err_count,   0);
        check("rst_match",    match_count, 0);
        check("rst_pulses",   {mismatch, even_err}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1: acquire lock on 1,3,5,7
        drive(1'b1, 11'd1, 1'b0);
        check("s1_acq1_locked", locked,   0);
        check("s1_acq1_exp",    expected, 3);
        drive(1'b1, 11'd3, 1'b0);
        drive(1'b1, 11'd5, 1'b0);
        check("s1_acq3_locked", locked,   0);
        check("s1_acq3_exp",    expected, 7);
        drive(1'b1, 11'd7, 1'b0);
        check("s1_locked",   locked,    1);
        check("s1_exp",      expected,  9);
        check("s1_err",      err_count, 0);
        check("s1_pulses",   {mismatch, even_err}, 0);
        check("s1_match",    match_count, 0);

        // Scenario 2: flywheel across a single mismatch
        drive(1'b1, 11'd9, 1'b0);
        drive(1'b1, 11'd11, 1'b0);
        check("s2_match2", match_count, 2);
        drive(1'b1, 11'd15, 1'b0);
        check("s2_mismatch", mismatch,  1);
        check("s2_err",      err_count, 1);
        check("s2_fly_exp",  expected,  15);
        drive(1'b1, 11'd15, 1'b0);
        check("s2_mis_clear", mismatch,    0);
        check("s2_match3",    match_count, 3);
        check("s2_locked",    locked,      1);
        check("s2_exp",       expected,    17);
        drive(1'b0, 11'd99, 1'b0);
        check("s2_hold_exp",   expected,    17);
        check("s2_hold_match", match_count, 3);

        // Scenario 3: three consecutive mismatches drop lock
        do_reset();
        lock_up();
        check("s3_locked", locked, 1);
        drive(1'b1, 11'd21, 1'b0);
        check("s3_mis1", mismatch, 1);
        check("s3_lk1",  locked,   1);
        drive(1'b1, 11'd23, 1'b0);
        check("s3_mis2", mismatch, 1);
        drive(1'b1, 11'd25, 1'b0);
        check("s3_mis3",    mismatch,  1);
        check("s3_err",     err_count, 3);
        check("s3_unlock",  locked,    0);
        check("s3_fly_exp", expected,  15);
        drive(1'b1, 11'd27, 1'b0);
        check("s3_reacq_exp", expected, 29);
        check("s3_reacq_lk",  locked,   0);
        check("s3_reacq_mis", mismatch, 0);
        check("s3_reacq_err", err_count, 3);

        // Scenario 4: wrap 15 -> 1 on the 4-bit instance
        drive4(1'b1, 4'd11);
        drive4(1'b1, 4'd13);
        drive4(1'b1, 4'd15);
        check("s4_wrap_exp", expected_4, 1);
        check("s4_prelock",  locked_4,   0);
        drive4(1'b1, 4'd1);
        check("s4_locked", locked_4,    1);
        check("s4_err",    err_count_4, 0);
        drive4(1'b1, 4'd3);
        check("s4_exp",   expected_4,    5);
        check("s4_match", match_count_4, 1);
        check("s4_mis",   mismatch_4,    0);
        drive4(1'b0, 4'd0);

        // Scenario 5: even sample in SEARCH, then clear beats increment
        do_reset();
        drive(1'b1, 11'd4, 1'b0);
        check("s5_even",   even_err,  1);
        check("s5_err",    err_count, 1);
        check("s5_exp",    expected,  1);
        check("s5_locked", locked,    0);
        drive(1'b1, 11'd3, 1'b0);
        check("s5_even_clear", even_err, 0);
        check("s5_search_exp", expected, 5);
        drive(1'b1, 11'd6, 1'b1);
        check("s5_clr_err",  err_count, 0);
        check("s5_clr_even", even_err,  1);
        check("s5_hold_exp", expected,  5);

        // Even sample while LOCKED drops to SEARCH
        do_reset();
        lock_up();
        drive(1'b1, 11'd8, 1'b0);
        check("s5b_even",   even_err, 1);
        check("s5b_unlock", locked,   0);
        check("s5b_exp",    expected, 9);
        check("s5b_err",    err_count, 1);

        // Scenario 6: async reset mid-stream with valid gaps
        do_reset();
        drive(1'b1, 11'd1, 1'b0);
        drive(1'b0, 11'd0, 1'b0);
        drive(1'b1, 11'd3, 1'b0);
        drive(1'b1, 11'd5, 1'b0);
        drive(1'b0, 11'd0, 1'b0);
        drive(1'b1, 11'd7, 1'b0);
        check("s6_locked", locked, 1);
        drive(1'b1, 11'd9, 1'b0);
        drive(1'b1, 11'd13, 1'b0);
        check("s6_pre_match", match_count, 1);
        check("s6_pre_err",   err_count,   1);
        @(negedge clk);
        sample_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("s6_rst_locked", locked,      0);
        check("s6_rst_exp",    expected,    1);
        check("s6_rst_err",    err_count,   0);
        check("s6_rst_match",  match_count, 0);
        check("s6_rst_pulses", {mismatch, even_err}, 0);
        @(negedge clk);
        reset = 1'b0;
        lock_up();
        check("s6_relock",     locked,    1);
        check("s6_relock_exp", expected,  9);
        check("s6_relock_err", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
